// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: DEPTH-stage valid/ready register pipeline with flush and programmable reset value.
// Optional occupancy counter enabled by defining PIPE_OCC_EN. Rev 1.0
`default_nettype none

module elastic_pipe_reg #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];
  logic [DEPTH:0]   rdy;

  // A stage can load when it is empty or its own word moves on this cycle.
  assign rdy[DEPTH] = out_ready;
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
      assign rdy[i] = ~vld[i] | rdy[i+1];
    end
  endgenerate

  assign in_ready  = rdy[0];
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat[i] <= RESET_VAL;
      end
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (rdy[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          dat[0] <= in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            dat[i] <= dat[i-1];
          end
        end
      end
    end
  end

`ifdef PIPE_OCC_EN
  localparam int OCC_W = $clog2(DEPTH+1);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & rdy[0];
  assign out_xfer = vld[DEPTH-1] & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: three depths (2, 4, 1) driven by shared stimulus, each checked
// against a slot-occupancy model plus an in-order delivery scoreboard.
`default_nettype none

module tb_elastic_pipe_reg;

  localparam int NI = 3;
  localparam int DEP [NI] = '{2, 4, 1};
  localparam logic [7:0] RV [NI] = '{8'hA5, 8'h5A, 8'h3C};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;

  logic [NI-1:0] irdy;
  logic [NI-1:0] ovld;
  logic [7:0]    odat [NI];

`ifdef PIPE_OCC_EN
  logic [1:0] occ_a;
  logic [2:0] occ_b;
  logic [0:0] occ_c;
`endif

  always #5 clk = ~clk;

  elastic_pipe_reg #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'hA5)) u_d2 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[0]), .in_data(in_data),
    .out_valid(ovld[0]), .out_ready(out_ready), .out_data(odat[0])
`ifdef PIPE_OCC_EN
    , .occupancy(occ_a)
`endif
  );

  elastic_pipe_reg #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A)) u_d4 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[1]), .in_data(in_data),
    .out_valid(ovld[1]), .out_ready(out_ready), .out_data(odat[1])
`ifdef PIPE_OCC_EN
    , .occupancy(occ_b)
`endif
  );

  elastic_pipe_reg #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h3C)) u_d1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[2]), .in_data(in_data),
    .out_valid(ovld[2]), .out_ready(out_ready), .out_data(odat[2])
`ifdef PIPE_OCC_EN
    , .occupancy(occ_c)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which slots hold a word and what it is; words advance toward the output when the slot ahead frees up.
  bit         m_v [NI][4];
  logic [7:0] m_d [NI][4];
  // Scoreboard of accepted words awaiting delivery, as a ring.
  logic [7:0] sb [NI][8];
  int         sb_rd [NI];
  int         sb_wr [NI];
  bit         armed = 1'b0;
  bit         rst_fresh = 1'b0;
  logic [7:0] seen33 = 8'h00;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_count(input int k);
    int c = 0;
    for (int i = 0; i < DEP[k]; i++) c += int'(m_v[k][i]);
    return c;
  endfunction

  function automatic int dut_occ(input int k);
`ifdef PIPE_OCC_EN
    case (k)
      0:       return int'(occ_a);
      1:       return int'(occ_b);
      default: return int'(occ_c);
    endcase
`else
    return k - k;
`endif
  endfunction

  task automatic step(input bit iv, input logic [7:0] id, input bit ordy, input bit fl, input bit rst);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    #1;
    for (int k = 0; k < NI; k++) begin
      int  d   = DEP[k];
      int  cnt = model_count(k);
      bit  nv [4];
      logic [7:0] nd [4];
      if (armed) begin
        chk($sformatf("d%0d_out_valid", d), int'(ovld[k]), int'(m_v[k][d-1]));
        chk($sformatf("d%0d_in_ready", d), int'(irdy[k]), int'((cnt < d) || ordy));
        if (m_v[k][d-1]) chk($sformatf("d%0d_out_data", d), int'(odat[k]), int'(m_d[k][d-1]));
        if (rst_fresh) chk($sformatf("d%0d_reset_data", d), int'(odat[k]), int'(RV[k]));
`ifdef PIPE_OCC_EN
        chk($sformatf("d%0d_occupancy", d), dut_occ(k), cnt);
`endif
      end
      // Advance the model across the coming rising edge.
      for (int i = 0; i < 4; i++) begin nv[i] = 1'b0; nd[i] = 8'h00; end
      if (rst) begin
        for (int i = 0; i < 4; i++) begin m_v[k][i] = 1'b0; m_d[k][i] = RV[k]; end
        sb_rd[k] = 0;
        sb_wr[k] = 0;
      end else begin
        if (m_v[k][d-1] && ordy) begin
          if (armed) begin
            chk($sformatf("d%0d_sb_nonempty", d), int'(sb_wr[k] != sb_rd[k]), 1);
            chk($sformatf("d%0d_order", d), int'(odat[k]), int'(sb[k][sb_rd[k] % 8]));
            if (odat[k] == 8'h33 && ovld[k]) seen33 = seen33 + 8'h01;
          end
          sb_rd[k]++;
        end
        if (fl) begin
          for (int i = 0; i < 4; i++) m_v[k][i] = 1'b0;
          sb_rd[k] = sb_wr[k];
        end else begin
          for (int i = d - 1; i >= 0; i--) begin
            if (m_v[k][i]) begin
              if (i == d - 1) begin
                if (!ordy) begin nv[i] = 1'b1; nd[i] = m_d[k][i]; end
              end else if (!nv[i+1]) begin
                nv[i+1] = 1'b1; nd[i+1] = m_d[k][i];
              end else begin
                nv[i] = 1'b1; nd[i] = m_d[k][i];
              end
            end
          end
          if (iv && !nv[0]) begin
            nv[0] = 1'b1;
            nd[0] = id;
            sb[k][sb_wr[k] % 8] = id;
            sb_wr[k]++;
          end
          for (int i = 0; i < 4; i++) begin m_v[k][i] = nv[i]; m_d[k][i] = nd[i]; end
        end
      end
    end
    rst_fresh = rst;
    if (rst) armed = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin sb_rd[k] = 0; sb_wr[k] = 0; end

    // Reset held for two cycles, then observe idle state.
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);

    // Streaming at full rate.
    for (int w = 1; w <= 8; w++) step(1, 8'(w), 1, 0, 0);
    for (int w = 0; w < 5; w++) step(0, 8'h00, 1, 0, 0);

    // Backpressure, then release.
    step(1, 8'h10, 0, 0, 0);
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h12, 0, 0, 0);
    step(1, 8'h12, 0, 0, 0);
    step(1, 8'h12, 0, 0, 0);
    step(1, 8'h12, 0, 0, 0);
    for (int w = 0; w < 6; w++) step(0, 8'h00, 1, 0, 0);

    // Full pipe with simultaneous in/out.
    for (int w = 0; w < 4; w++) step(1, 8'(8'h20 + w), 0, 0, 0);
    for (int w = 0; w < 6; w++) step(1, 8'(8'h40 + w), 1, 0, 0);

    // Flush with a word presented on the same edge; 0x33 must never emerge.
    for (int w = 0; w < 4; w++) step(1, 8'(8'h50 + w), 0, 0, 0);
    step(1, 8'h33, 0, 1, 0);
    for (int w = 0; w < 6; w++) step(0, 8'h00, 1, 0, 0);

    // Reset mid-stream, then first post-reset word.
    for (int w = 0; w < 3; w++) step(1, 8'(8'h60 + w), 1, 0, 0);
    step(1, 8'h6F, 1, 0, 1);
    step(1, 8'h70, 1, 0, 0);
    for (int w = 0; w < 5; w++) step(0, 8'h00, 1, 0, 0);

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 1500; c++) begin
      bit         iv   = ($urandom % 4) != 0;
      bit         ordy = ($urandom % 10) < 7;
      bit         fl   = ($urandom % 40) == 0;
      bit         rst  = ($urandom % 200) == 0;
      logic [7:0] dv   = 8'($urandom);
      if (dv == 8'h33) dv = 8'h34;
      step(iv, dv, ordy, fl, rst);
    end
    for (int w = 0; w < 6; w++) step(0, 8'h00, 1, 0, 0);

    chk("flushed_word_absent", int'(seen33), 0);
    for (int k = 0; k < NI; k++) chk($sformatf("d%0d_drained", DEP[k]), sb_wr[k] - sb_rd[k], 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
